// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: one MAC per cycle against an external weight ROM,
// then bias, saturation, optional ReLU, streamed out one neuron at a time with optional argmax.
module dense_layer_engine #(
    parameter int N_IN   = 196,
    parameter int N_OUT  = 10,
    parameter int IN_W   = 1,
    parameter int W_W    = 16,
    parameter int ACC_W  = 32,
    parameter int FRAC   = 12,
    parameter int RELU   = 1,
    parameter int ARGMAX = 0,
    localparam int AW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_IN*IN_W-1:0] in_vec,
    output logic                 busy,
    output logic [AW-1:0]        w_addr,
    input  logic [W_W-1:0]       w_data,
    output logic [NW-1:0]        b_addr,
    input  logic [W_W-1:0]       b_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [NW-1:0]        out_idx,
    output logic                 done,
    output logic [3:0]           class_idx,
    output logic [15:0]          class_val
);
    // out_valid/out_ready: a result transfers on a cycle where both are high; until then
    // out_valid stays high and out_data/out_idx are held, and the engine issues no addresses.

    typedef enum logic [1:0] {IDLE, MAC, FINISH, EMIT} state_t;

    localparam int            S      = (IN_W == 1) ? 0 : FRAC;
    localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);
    localparam logic [JW-1:0] J_ONE  = JW'(1);
    localparam logic [NW-1:0] N_ONE  = NW'(1);
    localparam logic [AW-1:0] A_ONE  = AW'(1);

    state_t                  state, state_nxt;
    logic [N_IN*IN_W-1:0]    in_q;
    logic [NW-1:0]           n;
    logic [JW-1:0]           j;
    logic [AW-1:0]           addr_q;
    logic signed [ACC_W-1:0] acc;
    logic                    last_j, last_n;

    logic [JW-1:0]           act_idx;
    logic [31:0]             act_base;
    logic [IN_W-1:0]         act;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_fin, acc_sh;
    logic signed [ACC_W:0]   r_wide;
    logic [15:0]             res;

    assign last_j = (j == J_LAST);
    assign last_n = (n == N_LAST);
    assign w_addr = addr_q;
    assign b_addr = n;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        out_valid = (state == EMIT);
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (last_j) state_nxt = FINISH;
            FINISH:  state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_n ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    // The ROM answers one cycle late, so each cycle consumes the product for the previous j.
    assign act_idx  = (state == FINISH) ? J_LAST : (j - J_ONE);
    assign act_base = 32'(act_idx) * IN_W;
    assign act      = in_q[act_base +: IN_W];

    generate
        if (IN_W == 1) begin : g_bin
            assign prod = act[0] ? ACC_W'($signed(w_data)) : '0;
        end else begin : g_mul
            logic signed [IN_W+W_W-1:0] p_full;
            assign p_full = $signed(act) * $signed(w_data);
            assign prod   = ACC_W'(p_full);
        end
    endgenerate

    always_comb begin
        acc_fin = acc + prod;
        acc_sh  = acc_fin >>> S;
        r_wide  = (ACC_W+1)'(acc_sh) + (ACC_W+1)'($signed(b_data));
        if (r_wide > 32767)       res = 16'h7FFF;
        else if (r_wide < -32768) res = 16'h8000;
        else                      res = r_wide[15:0];
        if (RELU != 0 && res[15]) res = 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q      <= '0;
            n         <= '0;
            j         <= '0;
            addr_q    <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
            class_idx <= '0;
            class_val <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    in_q      <= in_vec;
                    n         <= '0;
                    j         <= '0;
                    addr_q    <= '0;
                    acc       <= '0;
                    class_idx <= '0;
                    class_val <= '0;
                end
                MAC: begin
                    if (j != '0) acc <= acc + prod;
                    if (!last_j) begin
                        j      <= j + J_ONE;
                        addr_q <= addr_q + A_ONE;
                    end
                end
                FINISH: begin
                    out_data <= res;
                    out_idx  <= n;
                end
                EMIT: if (out_ready) begin
                    if (ARGMAX != 0 && (n == '0 || $signed(out_data) > $signed(class_val))) begin
                        class_idx <= 4'(n);
                        class_val <= out_data;
                    end
                    if (last_n) begin
                        done <= 1'b1;
                    end else begin
                        n      <= n + N_ONE;
                        j      <= '0;
                        acc    <= '0;
                        addr_q <= addr_q + A_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine: binary mode, back-pressure, start/in_vec disturbance,
// mid-pass reset, Q3.12 saturation with and without ReLU, and argmax tie-breaking with N_IN=1.
module tb_dense_layer_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // ---------------- instance A: binary, N_IN=4, N_OUT=3, ReLU ----------------
  logic        start_a, ready_a, busy_a, valid_a, done_a;
  logic [3:0]  vec_a, waddr_a, cidx_a;
  logic [1:0]  baddr_a, idx_a;
  logic [15:0] wdata_a, bdata_a, data_a, cval_a;
  logic [15:0] wrom_a[0:15];
  logic [15:0] brom_a[0:3];

  dense_layer_engine #(.N_IN(4), .N_OUT(3), .IN_W(1), .RELU(1), .ARGMAX(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_vec(vec_a), .busy(busy_a),
    .w_addr(waddr_a), .w_data(wdata_a), .b_addr(baddr_a), .b_data(bdata_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_idx(idx_a),
    .done(done_a), .class_idx(cidx_a), .class_val(cval_a)
  );

  // ------------- instances S/R: IN_W=16, N_IN=2, N_OUT=3, ReLU on/off -------------
  logic        start_s, busy_s, valid_s, done_s, busy_r, valid_r, done_r;
  logic [31:0] vec_s;
  logic [2:0]  waddr_s, waddr_r;
  logic [1:0]  baddr_s, idx_s, baddr_r, idx_r;
  logic [3:0]  cidx_s, cidx_r;
  logic [15:0] wdata_s, bdata_s, data_s, cval_s, wdata_r, bdata_r, data_r, cval_r;
  logic [15:0] wrom_s[0:7];
  logic [15:0] brom_s[0:3];

  dense_layer_engine #(.N_IN(2), .N_OUT(3), .IN_W(16), .RELU(1), .ARGMAX(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_vec(vec_s), .busy(busy_s),
    .w_addr(waddr_s), .w_data(wdata_s), .b_addr(baddr_s), .b_data(bdata_s),
    .out_valid(valid_s), .out_ready(1'b1), .out_data(data_s), .out_idx(idx_s),
    .done(done_s), .class_idx(cidx_s), .class_val(cval_s)
  );

  dense_layer_engine #(.N_IN(2), .N_OUT(3), .IN_W(16), .RELU(0), .ARGMAX(0)) dut_r (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_vec(vec_s), .busy(busy_r),
    .w_addr(waddr_r), .w_data(wdata_r), .b_addr(baddr_r), .b_data(bdata_r),
    .out_valid(valid_r), .out_ready(1'b1), .out_data(data_r), .out_idx(idx_r),
    .done(done_r), .class_idx(cidx_r), .class_val(cval_r)
  );

  // ---------------- instance M: N_IN=1, N_OUT=10, argmax ----------------
  logic        start_m, busy_m, valid_m, done_m;
  logic [0:0]  vec_m;
  logic [3:0]  waddr_m, baddr_m, idx_m, cidx_m;
  logic [15:0] wdata_m, bdata_m, data_m, cval_m;
  logic [15:0] wrom_m[0:15];

  dense_layer_engine #(.N_IN(1), .N_OUT(10), .IN_W(1), .RELU(0), .ARGMAX(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .in_vec(vec_m), .busy(busy_m),
    .w_addr(waddr_m), .w_data(wdata_m), .b_addr(baddr_m), .b_data(bdata_m),
    .out_valid(valid_m), .out_ready(1'b1), .out_data(data_m), .out_idx(idx_m),
    .done(done_m), .class_idx(cidx_m), .class_val(cval_m)
  );

  // ROM models: one-cycle read latency
  always @(posedge clk) begin
    wdata_a <= wrom_a[waddr_a];
    bdata_a <= brom_a[baddr_a];
    wdata_s <= wrom_s[waddr_s];
    bdata_s <= brom_s[baddr_s];
    wdata_r <= wrom_s[waddr_r];
    bdata_r <= brom_s[baddr_r];
    wdata_m <= wrom_m[waddr_m];
    bdata_m <= 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push3(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  // One pass on instance A; optional stall of one neuron and optional mid-pass disturbance.
  task automatic pass_a(input logic [3:0] vec, input int stall_n, input int stall_len,
                        input bit disturb, output int cycles);
    int hs;
    int st;
    logic [15:0] hold_d;
    logic [3:0]  hold_w;
    hs = 0; st = 0; cycles = 0; hold_d = '0; hold_w = '0;
    vec_a = vec; start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_busy_start", 32'(busy_a), 1);
    check("a_waddr_first", 32'(waddr_a), 0);
    while (!done_a && cycles < 200) begin
      if (disturb && cycles == 5) begin
        start_a = 1'b1;
        vec_a   = ~vec;
      end else begin
        start_a = 1'b0;
      end
      if (valid_a) begin
        if (hs == stall_n && st < stall_len) begin
          if (st == 0) begin
            hold_d = data_a;
            hold_w = waddr_a;
          end else begin
            check("a_stall_data", 32'(data_a), 32'(hold_d));
            check("a_stall_waddr", 32'(waddr_a), 32'(hold_w));
            check("a_stall_valid", 32'(valid_a), 1);
          end
          ready_a = 1'b0;
          st++;
        end else begin
          ready_a = 1'b1;
          if (exp_q.size() == 0) check("a_extra_result", 32'(data_a), 32'hFFFF_FFFF);
          else                   check("a_data", 32'(data_a), 32'(exp_q.pop_front()));
          check("a_idx", 32'(idx_a), 32'(hs));
          hs++;
        end
      end
      @(negedge clk);
      cycles++;
    end
    start_a = 1'b0;
    check("a_done_seen", 32'(done_a), 1);
    check("a_busy_at_done", 32'(busy_a), 0);
    check("a_handshakes", 32'(hs), 3);
    @(negedge clk);
    check("a_done_pulse", 32'(done_a), 0);
  endtask

  int cyc;
  int hs_s;
  int hs_m;
  logic [15:0] exp_s[0:2];
  logic [15:0] exp_r[0:2];
  logic [15:0] exp_m[0:9];

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_s = 1'b0; start_m = 1'b0; ready_a = 1'b1;
    vec_a = '0; vec_s = {16'h7000, 16'h7000}; vec_m = 1'b1;
    for (int i = 0; i < 16; i++) begin wrom_a[i] = 16'h0400; wrom_m[i] = 16'h0000; end
    for (int i = 0; i < 4; i++) begin brom_a[i] = 16'h0080; brom_s[i] = 16'h0000; end
    wrom_s[0] = 16'h7000; wrom_s[1] = 16'h7000;
    wrom_s[2] = 16'h9000; wrom_s[3] = 16'h9000;
    wrom_s[4] = 16'h0400; wrom_s[5] = 16'h0000;
    wrom_s[6] = 16'h0000; wrom_s[7] = 16'h0000;
    brom_s[2] = 16'h0123;
    exp_s[0] = 16'h7FFF; exp_s[1] = 16'h0000; exp_s[2] = 16'h1D23;
    exp_r[0] = 16'h7FFF; exp_r[1] = 16'h8000; exp_r[2] = 16'h1D23;
    exp_m[0] = 16'h0100; exp_m[1] = 16'h0200; exp_m[2] = 16'h0300; exp_m[3] = 16'h0500;
    exp_m[4] = 16'h0400; exp_m[5] = 16'hFF00; exp_m[6] = 16'h0000; exp_m[7] = 16'h0500;
    exp_m[8] = 16'h04FF; exp_m[9] = 16'h0010;
    for (int i = 0; i < 10; i++) wrom_m[i] = exp_m[i];

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_data", 32'(data_a), 0);
    check("rst_idx", 32'(idx_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_waddr", 32'(waddr_a), 0);
    check("rst_baddr", 32'(baddr_a), 0);
    check("rst_cidx", 32'(cidx_m), 0);
    check("rst_cval", 32'(cval_m), 0);
    check("rst_state", 32'(dut_a.state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // binary mode, uniform weights
    push3(16'h0880, 16'h0880, 16'h0880);
    pass_a(4'b0101, -1, 0, 1'b0, cyc);
    check("a_len_uniform", 32'(cyc), 18);

    // distinct weights per neuron, pixels 0,1,3 set
    wrom_a[0] = 16'h0100; wrom_a[1]  = 16'h0200; wrom_a[2]  = 16'h0400; wrom_a[3]  = 16'h0800;
    wrom_a[4] = 16'hFF00; wrom_a[5]  = 16'h0050; wrom_a[6]  = 16'h1000; wrom_a[7]  = 16'h0030;
    wrom_a[8] = 16'h0001; wrom_a[9]  = 16'h0002; wrom_a[10] = 16'h7000; wrom_a[11] = 16'h0004;
    brom_a[0] = 16'h0010; brom_a[1] = 16'h0100; brom_a[2] = 16'h0300;
    push3(16'h0B10, 16'h0080, 16'h0307);
    pass_a(4'b1011, -1, 0, 1'b0, cyc);
    check("a_len_plain", 32'(cyc), 18);

    // back-pressure on neuron 1 for 5 cycles
    push3(16'h0B10, 16'h0080, 16'h0307);
    pass_a(4'b1011, 1, 5, 1'b0, cyc);
    check("a_len_stall", 32'(cyc), 23);

    // start pulse and in_vec change mid-pass are ignored
    push3(16'h0B10, 16'h0080, 16'h0307);
    pass_a(4'b1011, -1, 0, 1'b1, cyc);
    check("a_len_disturb", 32'(cyc), 18);

    // reset during neuron 2 MAC
    vec_a = 4'b1011; start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_rst_busy", 32'(busy_a), 1);
    check("pre_rst_idx", 32'(idx_a), 1);
    check("pre_rst_data", 32'(data_a), 32'h0080);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_valid", 32'(valid_a), 0);
    check("mid_rst_data", 32'(data_a), 0);
    check("mid_rst_idx", 32'(idx_a), 0);
    check("mid_rst_waddr", 32'(waddr_a), 0);
    check("mid_rst_baddr", 32'(baddr_a), 0);
    check("mid_rst_state", 32'(dut_a.state), 0);
    @(negedge clk);
    push3(16'h0B10, 16'h0080, 16'h0307);
    pass_a(4'b1011, -1, 0, 1'b0, cyc);
    check("a_len_after_rst", 32'(cyc), 18);

    // Q3.12 saturation, ReLU on (S) and off (R)
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    cyc = 0; hs_s = 0;
    while (!done_s && cyc < 100) begin
      if (valid_s) begin
        if (hs_s < 3) begin
          check("s_data", 32'(data_s), 32'(exp_s[hs_s]));
          check("r_data", 32'(data_r), 32'(exp_r[hs_s]));
          check("s_idx", 32'(idx_s), 32'(hs_s));
          check("r_idx", 32'(idx_r), 32'(hs_s));
          check("r_valid", 32'(valid_r), 1);
        end else begin
          check("s_extra_result", 32'(hs_s), 3);
        end
        hs_s++;
      end
      @(negedge clk);
      cyc++;
    end
    check("s_done", 32'(done_s), 1);
    check("r_done", 32'(done_r), 1);
    check("s_len", 32'(cyc), 12);
    check("s_results", 32'(hs_s), 3);
    check("sr_busy", 32'({busy_s, busy_r}), 0);
    check("sr_class", 32'({cidx_s, cval_s, cidx_r, cval_r}), 0);

    // argmax with a tie between neurons 3 and 7, N_IN=1
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    cyc = 0; hs_m = 0;
    while (!done_m && cyc < 200) begin
      if (valid_m) begin
        if (hs_m < 10) begin
          check("m_data", 32'(data_m), 32'(exp_m[hs_m]));
          check("m_idx", 32'(idx_m), 32'(hs_m));
        end else begin
          check("m_extra_result", 32'(hs_m), 10);
        end
        hs_m++;
      end
      @(negedge clk);
      cyc++;
    end
    check("m_done", 32'(done_m), 1);
    check("m_busy", 32'(busy_m), 0);
    check("m_len", 32'(cyc), 30);
    check("m_class_idx", 32'(cidx_m), 3);
    check("m_class_val", 32'(cval_m), 32'h0500);
    @(negedge clk);
    check("m_class_hold", 32'({cidx_m, cval_m}), 32'h3_0500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Parametrised, time-multiplexed fully-connected layer for the MNIST classifier datapath. Computes N_OUT neurons, each as a dot product of a captured N_IN-element activation vector with weights fetched from an external ROM, plus bias, optional ReLU, and saturation. One MAC per cycle. Results stream out with a valid/ready handshake, and an optional argmax reports the winning class. Instances chain to form the 196-128-64-10 network, or larger ones.

## Interface
- N_IN, 196: activations per input vector
- N_OUT, 10: neurons computed
- IN_W, 1: activation width; 1 = binary pixel mode, >1 = signed Q(IN_W-FRAC).FRAC
- W_W, 16: signed weight/bias width, Q3.12
- ACC_W, 32: accumulator width
- FRAC, 12: fractional bits of weights and non-binary activations
- RELU, 1: 1 = clamp negative results to 0
- ARGMAX, 0: 1 = track the maximum output and report it at done
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  begin a layer pass; ignored unless IDLE
- in_vec  in  N_IN*IN_W  activation vector; element j = in_vec[j*IN_W +: IN_W]
- busy  out  1  high from the cycle after an accepted start until done
- w_addr  out  clog2(N_IN*N_OUT)  weight ROM address = n*N_IN + j
- w_data  in  W_W  weight; valid one cycle after w_addr
- b_addr  out  clog2(N_OUT)  bias ROM address = n
- b_data  in  W_W  bias; valid one cycle after b_addr
- out_valid  out  1  out_data holds a neuron result
- out_ready  in  1  consumer accepts the result
- out_data  out  16  signed Q3.12 result
- out_idx  out  clog2(N_OUT)  neuron index of out_data
- done  out  1  one-cycle pulse after the last result is accepted
- class_idx  out  4  argmax index (ARGMAX=1; otherwise 0)
- class_val  out  16  value at class_idx

## Operation
- States: IDLE, MAC, FINISH, EMIT.
- IDLE: when start=1, capture in_vec into an internal register, clear n, j and acc, and go to MAC. in_vec is not sampled again during the pass.
- MAC: drive w_addr=n*N_IN+j and j++ each cycle. Add the product returned for the previous address into acc. When j=N_IN-1, also drive b_addr=n, then go to FINISH.
- FINISH: add the last product. Form r = acc>>>S + sext(b_data), where S=0 when IN_W=1 and S=FRAC otherwise. Saturate r to 16-bit signed (0x7FFF/0x8000). Apply ReLU if RELU=1. Latch the result into out_data and out_idx=n. Go to EMIT.
- EMIT: hold out_valid=1 with stable out_data/out_idx until out_ready=1.
  - On the handshake cycle with ARGMAX=1: if n=0 or out_data > class_val (strict, signed), update class_idx/class_val. Ties keep the lower index.
  - Then if n<N_OUT-1: n++, clear acc and j, go to MAC.
  - Otherwise pulse done and go to IDLE.
- Product rules:
  - IN_W=1: the product is w_data if the pixel is 1, else 0. A pixel represents 1.0, so no shift is applied.
  - IN_W>1: signed IN_W×W_W multiply, sign-extended to ACC_W.
- acc wraps modulo 2^ACC_W. Saturation happens only at FINISH.
- class_idx and class_val hold their values until the next start, which clears them.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_idx=0, done=0, class_idx=0, class_val=0, w_addr=0, b_addr=0. State is IDLE.
- rst_n low mid-pass aborts on the next clock edge with all outputs at reset values. ROM responses already in flight are discarded.
- start is accepted at edge t. busy=1 from t+1. The first w_addr is driven in cycle t+1.
- Per neuron: N_IN MAC cycles + 1 FINISH + ≥1 EMIT. With out_ready tied high, a pass is N_OUT*(N_IN+2) cycles. done pulses one cycle after the final handshake; busy falls in that same cycle.
- out_valid never drops without a handshake. Back-pressure stalls the engine; no w_addr is issued while in EMIT.
- start while busy is ignored. start held high in IDLE at the cycle done falls restarts on the next edge.
- N_IN=1 is legal: MAC lasts one cycle and drives w_addr and b_addr together.

## Test plan
- Binary mode, N_IN=4, N_OUT=3, in_vec=4'b0101, all weights 0x0400, biases 0x0080 -> each out_data=0x0880, out_idx 0,1,2, done at 18 cycles after start (out_ready=1).
- Saturation and ReLU, IN_W=16, N_IN=2, activations 0x7000, weights 0x7000, RELU=1 -> out_data=0x7FFF. Repeat with negative weights 0x9000 -> 0x0000, and with RELU=0 -> 0x8000.
- Argmax tie, ARGMAX=1, neurons 3 and 7 both producing 0x0500, all others lower -> class_idx=3, class_val=0x0500 at done.
- Back-pressure: out_ready low for 5 cycles on neuron 1 -> out_valid and out_data stable, w_addr frozen, pass length +5 cycles, results identical to the unstalled run.
- Start while busy: second start pulse mid-pass is ignored, and in_vec changed mid-pass has no effect -> results match the originally captured vector.
- Reset mid-MAC on neuron 2: rst_n low for 1 cycle -> all outputs zero, state IDLE. A new start yields correct results from neuron 0.
